// File: rtl/mem_op_pkg.sv
// mem_op_pkg: shared opcode and FSM encodings for the memory-stage access unit.
package mem_op_pkg;
    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_SW  = 3'd3,
        OP_LBU = 3'd4,
        OP_LHU = 3'd5,
        OP_SB  = 3'd6,
        OP_SH  = 3'd7
    } op_e;

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_RMW_WRITE = 1'b1
    } state_e;

    localparam int WORD_SHIFT = 2;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline request/response and data-memory bus of the access unit.
interface mem_access_unit_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_address;
    logic [31:0] req_store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        fault;
    logic [31:0] fault_address;
    logic        dm_write_enable;
    logic [31:0] dm_address;
    logic [31:0] dm_write_data;
    logic [31:0] dm_read_data;

    modport slave (
        input  req_valid, req_op, req_address, req_store_data, dm_read_data,
        output stall, load_data, load_valid, fault, fault_address,
               dm_write_enable, dm_address, dm_write_data
    );

    modport master (
        output req_valid, req_op, req_address, req_store_data, dm_read_data,
        input  stall, load_data, load_valid, fault, fault_address,
               dm_write_enable, dm_address, dm_write_data
    );
endinterface

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half of a word and sign- or zero-extends it.
module load_align
    import mem_op_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  op_e         op_i,
    output logic [31:0] data_o
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = 8'(word_i >> {lane_i, 3'b000});
    assign h = lane_i[1] ? word_i[31:16] : word_i[15:0];
    assign data_o = op_i == OP_LB  ? {{24{b[7]}}, b} :
                    op_i == OP_LBU ? {24'd0, b} :
                    op_i == OP_LH  ? {{16{h[15]}}, h} :
                    op_i == OP_LHU ? {16'd0, h} : word_i;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MIPS memory-stage initiator with load alignment, fault checks and
// a two-cycle read-modify-write for sub-word stores.
module mem_access_unit
    import mem_op_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic              system_clock,
    input  logic              reset,
    mem_access_unit_if.slave  bus
);
    op_e         op, op_q;
    state_e      state_q, state_d;
    logic [31:0] word_addr, addr_q, rdata_q, store_q, mask, merged, aligned;
    logic [31:0] load_data_q, fault_addr_q;
    logic [1:0]  lane_q;
    logic        ld, sub, st, misalign, oor, idle_req, bad, load_acc;
    logic        load_valid_q, fault_q;

    assign op        = op_e'(bus.req_op);
    assign ld        = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    assign sub       = op inside {OP_SB, OP_SH};
    assign st        = sub || op == OP_SW;
    assign misalign  = (op inside {OP_LH, OP_LHU, OP_SH} && bus.req_address[0]) ||
                       (op inside {OP_LW, OP_SW} && bus.req_address[1:0] != 2'b00);
    assign oor       = (bus.req_address >> WORD_SHIFT) >= 32'(MEM_WORDS);
    assign idle_req  = state_q == S_IDLE && bus.req_valid && (ld || st) && !reset;
    assign bad       = idle_req && (misalign || oor);
    assign load_acc  = idle_req && ld && !bad;
    assign word_addr = {bus.req_address[31:2], 2'b00};

    // Sub-word store: replace only the addressed lane of the word read in the first cycle.
    assign mask   = op_q == OP_SB ? 32'hFF << {lane_q, 3'b000} : 32'hFFFF << {lane_q[1], 4'b0000};
    assign merged = (rdata_q & ~mask) | ((store_q << {lane_q, 3'b000}) & mask);

    load_align u_align (
        .word_i (bus.dm_read_data),
        .lane_i (bus.req_address[1:0]),
        .op_i   (op),
        .data_o (aligned)
    );

    always_comb begin
        state_d             = state_q;
        bus.stall           = 1'b0;
        bus.dm_write_enable = 1'b0;
        bus.dm_address      = 32'd0;
        bus.dm_write_data   = 32'd0;
        if (state_q == S_RMW_WRITE) begin
            state_d             = S_IDLE;
            bus.dm_address      = addr_q;
            bus.dm_write_data   = merged;
            bus.dm_write_enable = 1'b1;
        end else if (idle_req && !bad) begin
            bus.dm_address      = word_addr;
            bus.dm_write_enable = op == OP_SW;
            bus.dm_write_data   = op == OP_SW ? bus.req_store_data : 32'd0;
            bus.stall           = sub;
            state_d             = sub ? S_RMW_WRITE : S_IDLE;
        end
        if (reset) begin
            state_d             = S_IDLE;
            bus.stall           = 1'b0;
            bus.dm_write_enable = 1'b0;
        end
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            load_data_q  <= 32'd0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            load_valid_q <= load_acc;
            fault_q      <= bad;
            if (load_acc) load_data_q <= aligned;
            if (bad) fault_addr_q <= bus.req_address;
        end
    end

    always_ff @(posedge system_clock) begin
        if (state_q == S_IDLE && state_d == S_RMW_WRITE) begin
            rdata_q <= bus.dm_read_data;
            addr_q  <= word_addr;
            store_q <= bus.req_store_data;
            op_q    <= op;
            lane_q  <= bus.req_address[1:0];
        end
    end

    assign bus.load_data     = load_data_q;
    assign bus.load_valid    = load_valid_q;
    assign bus.fault         = fault_q;
    assign bus.fault_address = fault_addr_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a behavioural 64-word data memory.
module tb_mem_access_unit;
    import mem_op_pkg::*;

    typedef struct packed {
        logic        flt;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem [64];
    int          wr_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        q[$];

    mem_access_unit_if bus();

    mem_access_unit #(.MEM_WORDS(64)) dut (
        .system_clock (clk),
        .reset        (rst),
        .bus          (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.dm_read_data = mem[bus.dm_address[7:2]];

    always @(posedge clk) begin
        if (bus.dm_write_enable === 1'b1) begin
            mem[bus.dm_address[7:2]] <= bus.dm_write_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Registered outputs are compared on the falling edge, in issue order.
    always @(negedge clk) begin
        if (bus.load_valid === 1'b1 || bus.fault === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_out", {bus.fault, bus.load_valid}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.flt) begin
                    chk("fault_flag", bus.fault, 1);
                    chk("fault_lv", bus.load_valid, 0);
                    chk("fault_addr", bus.fault_address, e.val);
                end else begin
                    chk("load_fault", bus.fault, 0);
                    chk("load_data", bus.load_data, e.val);
                end
            end
        end
    end

    // kind: 0 = store expected to succeed, 1 = load with value v, 2 = fault at address v
    task automatic issue(input string tag, input op_e op, input logic [31:0] a,
                         input logic [31:0] d, input int kind, input logic [31:0] v);
        logic s, w;
        bus.req_valid      = 1'b1;
        bus.req_op         = op;
        bus.req_address    = a;
        bus.req_store_data = d;
        if (kind == 1) q.push_back('{flt: 1'b0, val: v});
        if (kind == 2) q.push_back('{flt: 1'b1, val: v});
        #1;
        s = bus.stall;
        w = bus.dm_write_enable;
        if ((op == OP_SB || op == OP_SH) && kind == 0) begin
            chk({tag, "_stall1"}, s, 1);
            chk({tag, "_we1"}, w, 0);
        end
        if (op == OP_SW && kind == 0) begin
            chk({tag, "_we"}, w, 1);
            chk({tag, "_stall"}, s, 0);
        end
        if (kind == 2) chk({tag, "_we"}, w, 0);
        @(posedge clk);
        #1;
        if (s) begin
            chk({tag, "_stall2"}, bus.stall, 0);
            chk({tag, "_we2"}, bus.dm_write_enable, 1);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int pre;
        for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
        mem[1] <= 32'h8899AABB;
        mem[2] <= 32'h11223344;
        mem[3] <= 32'hDEADBEEF;
        rst                = 1'b1;
        bus.req_valid      = 1'b0;
        bus.req_op         = 3'd0;
        bus.req_address    = 32'd0;
        bus.req_store_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", bus.stall, 0);
        chk("rst_we", bus.dm_write_enable, 0);
        chk("rst_lv", bus.load_valid, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_ld", bus.load_data, 0);
        chk("rst_fa", bus.fault_address, 0);
        rst = 1'b0;

        issue("lb5", OP_LB, 32'h05, 0, 1, 32'hFFFFFFAA);
        issue("lbu5", OP_LBU, 32'h05, 0, 1, 32'h000000AA);
        issue("lb7", OP_LB, 32'h07, 0, 1, 32'hFFFFFF88);
        issue("lha", OP_LH, 32'h0A, 0, 1, 32'h00001122);
        issue("lhua", OP_LHU, 32'h0A, 0, 1, 32'h00001122);
        issue("lh8", OP_LH, 32'h08, 0, 1, 32'h00003344);
        issue("lhu6", OP_LHU, 32'h06, 0, 1, 32'h00008899);
        issue("lw4", OP_LW, 32'h04, 0, 1, 32'h8899AABB);
        #1;
        chk("idle_stall", bus.stall, 0);
        chk("idle_addr", bus.dm_address, 0);

        issue("sb", OP_SB, 32'h0E, 32'hAABBCC55, 0, 0);
        chk("sb_mem", mem[3], 32'hDE55BEEF);
        mem[3] <= 32'hDEADBEEF;
        @(posedge clk);
        #1;
        issue("sh", OP_SH, 32'h0C, 32'hFFFF1234, 0, 0);
        issue("sw", OP_SW, 32'h10, 32'hCAFEF00D, 0, 0);
        chk("sh_mem", mem[3], 32'hDEAD1234);
        chk("sw_mem", mem[4], 32'hCAFEF00D);
        issue("lw_c", OP_LW, 32'h0C, 0, 1, 32'hDEAD1234);

        pre = wr_cnt;
        issue("f_lw", OP_LW, 32'h06, 32'h1, 2, 32'h06);
        issue("f_sh", OP_SH, 32'h03, 32'h2, 2, 32'h03);
        issue("f_sw", OP_SW, 32'h100, 32'h3, 2, 32'h100);
        issue("f_sb", OP_SB, 32'h101, 32'h4, 2, 32'h101);
        @(posedge clk);
        #1;
        chk("f_nowrite", wr_cnt, pre);
        chk("f_mem4", mem[4], 32'hCAFEF00D);

        pre = wr_cnt;
        bus.req_valid      = 1'b1;
        bus.req_op         = OP_SB;
        bus.req_address    = 32'h09;
        bus.req_store_data = 32'h77;
        #1;
        chk("rr_stall1", bus.stall, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rr_we", bus.dm_write_enable, 0);
        chk("rr_stall", bus.stall, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        chk("rr_mem", mem[2], 32'h11223344);
        chk("rr_nowrite", wr_cnt, pre);
        chk("rr_ld", bus.load_data, 0);
        chk("rr_lv", bus.load_valid, 0);
        chk("rr_fault", bus.fault, 0);
        chk("rr_fa", bus.fault_address, 0);
        issue("rr_lw", OP_LW, 32'h08, 0, 1, 32'h11223344);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
